mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage sitting directly downstream of the ALU: consumes the ALU result together with the instruction code, destination register and store operand. It performs the load/store bus transaction with a request/acknowledge handshake, aligns and extends load data, and presents one write-back result per instruction. Non-memory results pass straight through to write-back. Multi-cycle only for loads and stores.

## Interface
- WIDTH, 32, datapath width; only 32 supported (4 byte lanes)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  ALU result valid this cycle
- req_ready  out  1  stage can accept; high iff state IDLE
- instr_in  in  6  instruction code (shared i_* encoding)
- addr  in  WIDTH  ALU result (effective address for loads/stores, else result)
- store_data  in  WIDTH  rs2 value for stores
- rd  in  5  destination register
- mem_req  out  1  bus request, held until ack
- mem_we  out  1  1 = store
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte-lane strobes (0 for loads)
- mem_ack  in  1  bus completion; mem_rdata valid same cycle for loads
- mem_rdata  in  32  load data word
- wb_valid  out  1  one-cycle write-back pulse
- wb_rd  out  5  write-back register
- wb_data  out  WIDTH  write-back value
- misalign  out  1  one-cycle misaligned-access pulse

## Operation
- FSM states IDLE, BUS. Accept = req_valid && req_ready.
- Accept in IDLE, classified by instr_in:
  - load (lb, lh, lw, lbu, lhu) / store (sb, sh, sw), aligned -> register addr/data/strobes, go BUS.
  - misaligned (lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0) -> no bus cycle, misalign=1 next cycle, no write-back, stay IDLE.
  - branches (beq, bne, blt, bge, bltu, bgeu), jal, jalr -> consumed, no output.
  - all other codes -> wb_valid=1 next cycle, wb_data=addr, wb_rd=rd; stay IDLE.
- BUS: mem_req=1 with mem_addr/mem_we/mem_wdata/mem_wstrb stable until mem_ack sampled high; then IDLE.
- Store strobes: sb 4'b0001<<addr[1:0], wdata = byte replicated x4; sh 4'b0011<<{addr[1],1'b0}, wdata = half replicated x2; sw 4'b1111.
- Load extract on ack: lane selected by addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend, lw full word. Load -> wb_valid next cycle with extracted data and latched rd. Store -> no write-back.
- rd=0 still produces wb_valid; regfile discards.
- mem_ack in IDLE ignored.

## Timing
- Reset (any state): next edge state IDLE; mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, wb_valid, wb_rd, wb_data, misalign all 0; req_ready=1. Aborted bus request is dropped; a late ack is ignored.
- Pass-through: accept at T -> wb_valid at T+1; throughput one per cycle.
- Memory op: accept at T -> mem_req high from T+1; ack earliest at T+1. Ack at cycle A -> mem_req low and req_ready high at A+1; load wb_valid at A+1. A new accept at A+1 coexists with the load's wb pulse; its own output appears at A+2 or later.
- req_ready combinational from state only (no dependence on req_valid).
- wb_valid and misalign never high together; each at most one cycle per instruction.

## Structure
- i_* instruction codes come from the shared instructions include; add lsu size encodings (BYTE, HALF, WORD) and FSM state constants there.
- One sub-module: mem_align, combinational, computing mem_wstrb/mem_wdata from (size, addr[1:0], store_data) and load extract/extend from (size, unsigned, addr[1:0], mem_rdata). Top contains FSM and registers.

## Test plan
- Reset: assert rst for 2 cycles while in BUS -> all outputs 0, req_ready=1; ack pulsed afterwards produces no wb_valid.
- Pass-through: back-to-back i_add addr=0x0000_0005 rd=3, i_xori addr=0xFFFF_FFFF rd=4 -> wb_valid on consecutive cycles with (3,0x5), (4,0xFFFFFFFF).
- sb addr=0x1003 store_data=0x0000_00AB, ack after 3 cycles -> mem_addr=0x1000, wstrb=4'b1000, wdata=0xABABABAB, mem_req held 3 cycles, no wb.
- lb addr=0x2002, rdata=0x0080_0000, ack immediate -> wb_data=0xFFFF_FF80; same with lbu -> 0x0000_0080; lh addr=0x2002 rdata=0x8001_0000 -> 0xFFFF8001.
- lw addr=0x3001 -> misalign pulse T+1, mem_req never asserted, no wb; sh addr=0x3002 -> normal store, wstrb=4'b1100.
- beq accepted -> no wb_valid, no mem_req, req_ready stays 1.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared instruction codes, load/store size encodings and FSM states for the
// memory-access stage, plus small decode helpers.
package mem_stage_pkg;

    localparam logic [5:0] i_nop   = 6'd0;
    localparam logic [5:0] i_add   = 6'd1;
    localparam logic [5:0] i_sub   = 6'd2;
    localparam logic [5:0] i_and   = 6'd3;
    localparam logic [5:0] i_or    = 6'd4;
    localparam logic [5:0] i_xor   = 6'd5;
    localparam logic [5:0] i_sll   = 6'd6;
    localparam logic [5:0] i_srl   = 6'd7;
    localparam logic [5:0] i_sra   = 6'd8;
    localparam logic [5:0] i_slt   = 6'd9;
    localparam logic [5:0] i_sltu  = 6'd10;
    localparam logic [5:0] i_addi  = 6'd11;
    localparam logic [5:0] i_andi  = 6'd12;
    localparam logic [5:0] i_ori   = 6'd13;
    localparam logic [5:0] i_xori  = 6'd14;
    localparam logic [5:0] i_lui   = 6'd15;
    localparam logic [5:0] i_auipc = 6'd16;
    localparam logic [5:0] i_lb    = 6'd17;
    localparam logic [5:0] i_lh    = 6'd18;
    localparam logic [5:0] i_lw    = 6'd19;
    localparam logic [5:0] i_lbu   = 6'd20;
    localparam logic [5:0] i_lhu   = 6'd21;
    localparam logic [5:0] i_sb    = 6'd22;
    localparam logic [5:0] i_sh    = 6'd23;
    localparam logic [5:0] i_sw    = 6'd24;
    localparam logic [5:0] i_beq   = 6'd25;
    localparam logic [5:0] i_bne   = 6'd26;
    localparam logic [5:0] i_blt   = 6'd27;
    localparam logic [5:0] i_bge   = 6'd28;
    localparam logic [5:0] i_bltu  = 6'd29;
    localparam logic [5:0] i_bgeu  = 6'd30;
    localparam logic [5:0] i_jal   = 6'd31;
    localparam logic [5:0] i_jalr  = 6'd32;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } lsu_size_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    function automatic logic is_load(input logic [5:0] op);
        return op inside {i_lb, i_lh, i_lw, i_lbu, i_lhu};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {i_sb, i_sh, i_sw};
    endfunction

    // Control-flow ops are already resolved upstream; nothing to write back here.
    function automatic logic is_ctrl(input logic [5:0] op);
        return op inside {i_beq, i_bne, i_blt, i_bge, i_bltu, i_bgeu, i_jal, i_jalr};
    endfunction

    function automatic lsu_size_t lsu_size(input logic [5:0] op);
        lsu_size_t sz;
        case (op)
            i_lb, i_lbu, i_sb: sz = BYTE;
            i_lh, i_lhu, i_sh: sz = HALF;
            default:           sz = WORD;
        endcase
        return sz;
    endfunction

    function automatic logic lsu_unsigned(input logic [5:0] op);
        return op inside {i_lbu, i_lhu};
    endfunction

    function automatic logic is_misaligned(input lsu_size_t sz, input logic [1:0] off);
        logic mis;
        case (sz)
            HALF:    mis = off[0];
            WORD:    mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Byte-lane steering: store strobes/replicated write data, and load lane
// extraction with sign or zero extension.
module mem_align
    import mem_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       size,
    input  logic             is_unsigned,
    input  logic [1:0]       off,
    input  logic [WIDTH-1:0] store_data,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [3:0]       wstrb,
    output logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] load_data
);

    logic signed [7:0]       lane_b;
    logic signed [15:0]      lane_h;
    logic signed [WIDTH-1:0] sext_b;
    logic signed [WIDTH-1:0] sext_h;

    always_comb begin
        wstrb = 4'b0000;
        wdata = '0;
        case (lsu_size_t'(size))
            BYTE: begin
                wstrb = 4'b0001 << off;
                wdata = {4{store_data[7:0]}};
            end
            HALF: begin
                wstrb = 4'b0011 << {off[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                wstrb = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    // Signed lanes widen by sign extension on assignment to the wider signed vars.
    always_comb begin
        lane_b    = mem_rdata[{off, 3'b000} +: 8];
        lane_h    = mem_rdata[{off[1], 4'b0000} +: 16];
        sext_b    = lane_b;
        sext_h    = lane_h;
        load_data = mem_rdata;
        case (lsu_size_t'(size))
            BYTE:    load_data = is_unsigned ? {{(WIDTH-8){1'b0}}, lane_b}  : sext_b;
            HALF:    load_data = is_unsigned ? {{(WIDTH-16){1'b0}}, lane_h} : sext_h;
            default: load_data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: IDLE/BUS handshake FSM for loads and stores, single-cycle
// pass-through of ALU results, one write-back or misalign pulse per instruction.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [5:0]       instr_in,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] store_data,
    input  logic [4:0]       rd,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic             misalign
);

    state_t     state, state_nxt;
    logic       accept;
    logic       in_load, in_store, in_ctrl, in_mis, in_uns;
    lsu_size_t  in_size;

    lsu_size_t  size_p0;
    logic       uns_p0;
    logic [1:0] off_p0;
    logic [4:0] rd_p0;
    logic       ld_p0;

    logic [1:0]       al_size;
    logic             al_uns;
    logic [1:0]       al_off;
    logic [3:0]       al_wstrb;
    logic [WIDTH-1:0] al_wdata;
    logic [WIDTH-1:0] al_load;

    assign req_ready = (state == IDLE);
    assign mem_req   = (state == BUS);
    assign accept    = req_valid && req_ready;

    assign in_load  = is_load(instr_in);
    assign in_store = is_store(instr_in);
    assign in_ctrl  = is_ctrl(instr_in);
    assign in_size  = lsu_size(instr_in);
    assign in_uns   = lsu_unsigned(instr_in);
    assign in_mis   = is_misaligned(in_size, addr[1:0]);

    // The aligner serves stores at accept (IDLE) and load extraction at ack (BUS).
    assign al_size = (state == IDLE) ? in_size    : size_p0;
    assign al_uns  = (state == IDLE) ? in_uns     : uns_p0;
    assign al_off  = (state == IDLE) ? addr[1:0]  : off_p0;

    mem_align #(.WIDTH(WIDTH)) u_align (
        .size        (al_size),
        .is_unsigned (al_uns),
        .off         (al_off),
        .store_data  (store_data),
        .mem_rdata   (mem_rdata),
        .wstrb       (al_wstrb),
        .wdata       (al_wdata),
        .load_data   (al_load)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && (in_load || in_store) && !in_mis) state_nxt = BUS;
            BUS:     if (mem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- stage p0: latch load context at accept ----
    always_ff @(posedge clk) begin
        if (accept) begin
            size_p0 <= in_size;
            uns_p0  <= in_uns;
            off_p0  <= addr[1:0];
            rd_p0   <= rd;
        end
    end

    // ---- stage p1: bus request registers and write-back ----
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= 4'b0000;
            ld_p0     <= 1'b0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            misalign  <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            misalign <= 1'b0;
            if (accept) begin
                if (in_load || in_store) begin
                    if (in_mis) begin
                        misalign <= 1'b1;
                    end else begin
                        mem_addr  <= {addr[31:2], 2'b00};
                        mem_we    <= in_store;
                        mem_wstrb <= in_store ? al_wstrb : 4'b0000;
                        mem_wdata <= in_store ? al_wdata : '0;
                        ld_p0     <= in_load;
                    end
                end else if (!in_ctrl) begin
                    wb_valid <= 1'b1;
                    wb_rd    <= rd;
                    wb_data  <= addr;
                end
            end
            if (state == BUS && mem_ack && ld_p0) begin
                wb_valid <= 1'b1;
                wb_rd    <= rd_p0;
                wb_data  <= al_load;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, hand-written multi-cycle
// sequences, and randomized ops checked against a behavioural model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  instr_in = 6'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .instr_in   (instr_in),
        .addr       (addr),
        .store_data (store_data),
        .rd         (rd),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .misalign   (misalign)
    );

    typedef enum int {K_WB, K_NONE, K_MIS, K_LOAD, K_STORE} kind_e;

    typedef struct {
        logic [5:0]  instr;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          delay;
        kind_e       kind;
        logic [31:0] exp_data;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] instr, input logic [31:0] a, input logic [31:0] sd,
                                input logic [4:0] r, input logic [31:0] rdat, input int dly,
                                input kind_e k, input logic [31:0] ed, input logic [3:0] es,
                                input logic [31:0] ew);
        vec_t v;
        v.instr = instr; v.addr = a; v.sdata = sd; v.rd = r; v.rdata = rdat; v.delay = dly;
        v.kind = k; v.exp_data = ed; v.exp_strb = es; v.exp_wdata = ew;
        return v;
    endfunction

    // Reference behaviour from the instruction semantics, using plain arithmetic.
    function automatic vec_t model(input logic [5:0] instr, input logic [31:0] a, input logic [31:0] sd,
                                   input logic [4:0] r, input logic [31:0] rdat, input int dly);
        vec_t v;
        int unsigned off;
        logic [31:0] lane;
        v = mk(instr, a, sd, r, rdat, dly, K_WB, a, 4'h0, 32'h0);
        off = a % 4;
        case (instr)
            i_lb, i_lbu: begin
                lane = (rdat >> (8 * off)) & 32'hFF;
                if (instr == i_lb && lane >= 32'd128) lane = lane - 32'd256;
                v.kind = K_LOAD; v.exp_data = lane;
            end
            i_lh, i_lhu: begin
                lane = (rdat >> (8 * off)) & 32'hFFFF;
                if (instr == i_lh && lane >= 32'd32768) lane = lane - 32'd65536;
                v.kind = (off % 2 != 0) ? K_MIS : K_LOAD; v.exp_data = lane;
            end
            i_lw: begin
                v.kind = (off != 0) ? K_MIS : K_LOAD; v.exp_data = rdat;
            end
            i_sb: begin
                v.kind = K_STORE; v.exp_strb = 4'(1 << off);
                v.exp_wdata = (sd & 32'hFF) * 32'h0101_0101;
            end
            i_sh: begin
                v.kind = (off % 2 != 0) ? K_MIS : K_STORE; v.exp_strb = 4'(3 << off);
                v.exp_wdata = (sd & 32'hFFFF) * 32'h0001_0001;
            end
            i_sw: begin
                v.kind = (off != 0) ? K_MIS : K_STORE; v.exp_strb = 4'hF; v.exp_wdata = sd;
            end
            i_beq, i_bne, i_blt, i_bge, i_bltu, i_bgeu, i_jal, i_jalr: v.kind = K_NONE;
            default: v.kind = K_WB;
        endcase
        return v;
    endfunction

    // Starts and ends on a falling edge; accept happens on the edge in between.
    task automatic do_op(input vec_t v, input string tag);
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; instr_in = v.instr; addr = v.addr; store_data = v.sdata; rd = v.rd;
        @(negedge clk);
        req_valid = 1'b0; instr_in = 6'($urandom); addr = $urandom; store_data = $urandom;
        rd = 5'($urandom);
        case (v.kind)
            K_WB: begin
                check({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
                check({tag, ".wb_rd"}, 32'(wb_rd), 32'(v.rd));
                check({tag, ".wb_data"}, wb_data, v.exp_data);
                check({tag, ".misalign"}, 32'(misalign), 32'd0);
                check({tag, ".mem_req"}, 32'(mem_req), 32'd0);
            end
            K_NONE: begin
                check({tag, ".wb_valid"}, 32'(wb_valid), 32'd0);
                check({tag, ".misalign"}, 32'(misalign), 32'd0);
                check({tag, ".mem_req"}, 32'(mem_req), 32'd0);
                check({tag, ".ready_after"}, 32'(req_ready), 32'd1);
            end
            K_MIS: begin
                check({tag, ".misalign"}, 32'(misalign), 32'd1);
                check({tag, ".wb_valid"}, 32'(wb_valid), 32'd0);
                check({tag, ".mem_req"}, 32'(mem_req), 32'd0);
            end
            default: begin
                check({tag, ".ready_bus"}, 32'(req_ready), 32'd0);
                check({tag, ".mem_req"}, 32'(mem_req), 32'd1);
                check({tag, ".mem_addr"}, mem_addr, v.addr & 32'hFFFF_FFFC);
                check({tag, ".mem_we"}, 32'(mem_we), (v.kind == K_STORE) ? 32'd1 : 32'd0);
                check({tag, ".mem_wstrb"}, 32'(mem_wstrb), 32'(v.exp_strb));
                if (v.kind == K_STORE) check({tag, ".mem_wdata"}, mem_wdata, v.exp_wdata);
                for (int i = 1; i < v.delay; i++) begin
                    @(negedge clk);
                    check({tag, ".mem_req_hold"}, 32'(mem_req), 32'd1);
                    check({tag, ".mem_addr_hold"}, mem_addr, v.addr & 32'hFFFF_FFFC);
                    check({tag, ".mem_wstrb_hold"}, 32'(mem_wstrb), 32'(v.exp_strb));
                    check({tag, ".wb_wait"}, 32'(wb_valid), 32'd0);
                end
                mem_ack = 1'b1; mem_rdata = v.rdata;
                @(negedge clk);
                mem_ack = 1'b0; mem_rdata = $urandom;
                check({tag, ".mem_req_done"}, 32'(mem_req), 32'd0);
                check({tag, ".ready_done"}, 32'(req_ready), 32'd1);
                check({tag, ".misalign"}, 32'(misalign), 32'd0);
                if (v.kind == K_LOAD) begin
                    check({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
                    check({tag, ".wb_rd"}, 32'(wb_rd), 32'(v.rd));
                    check({tag, ".wb_data"}, wb_data, v.exp_data);
                end else begin
                    check({tag, ".wb_valid"}, 32'(wb_valid), 32'd0);
                end
            end
        endcase
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".mem_req"}, 32'(mem_req), 32'd0);
        check({tag, ".mem_we"}, 32'(mem_we), 32'd0);
        check({tag, ".mem_wstrb"}, 32'(mem_wstrb), 32'd0);
        check({tag, ".mem_addr"}, mem_addr, 32'd0);
        check({tag, ".mem_wdata"}, mem_wdata, 32'd0);
        check({tag, ".wb_valid"}, 32'(wb_valid), 32'd0);
        check({tag, ".wb_rd"}, 32'(wb_rd), 32'd0);
        check({tag, ".wb_data"}, wb_data, 32'd0);
        check({tag, ".misalign"}, 32'(misalign), 32'd0);
        check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    endtask

    vec_t tbl[16];
    logic [5:0] mem_ops[8];

    initial begin
        tbl[0]  = mk(i_add,  32'h1234_5678, 32'h0,         5'd7,  32'h0,         1, K_WB,    32'h1234_5678, 4'h0, 32'h0);
        tbl[1]  = mk(i_sub,  32'hDEAD_BEEF, 32'h0,         5'd0,  32'h0,         1, K_WB,    32'hDEAD_BEEF, 4'h0, 32'h0);
        tbl[2]  = mk(i_sb,   32'h0000_1003, 32'h0000_00AB, 5'd1,  32'h0,         3, K_STORE, 32'h0, 4'b1000, 32'hABAB_ABAB);
        tbl[3]  = mk(i_lb,   32'h0000_2002, 32'h0,         5'd5,  32'h0080_0000, 1, K_LOAD,  32'hFFFF_FF80, 4'h0, 32'h0);
        tbl[4]  = mk(i_lbu,  32'h0000_2002, 32'h0,         5'd6,  32'h0080_0000, 1, K_LOAD,  32'h0000_0080, 4'h0, 32'h0);
        tbl[5]  = mk(i_lh,   32'h0000_2002, 32'h0,         5'd8,  32'h8001_0000, 1, K_LOAD,  32'hFFFF_8001, 4'h0, 32'h0);
        tbl[6]  = mk(i_lhu,  32'h0000_2000, 32'h0,         5'd9,  32'h1234_F00D, 2, K_LOAD,  32'h0000_F00D, 4'h0, 32'h0);
        tbl[7]  = mk(i_lw,   32'h0000_3001, 32'h0,         5'd10, 32'h0,         1, K_MIS,   32'h0, 4'h0, 32'h0);
        tbl[8]  = mk(i_sh,   32'h0000_3002, 32'h1234_BEEF, 5'd11, 32'h0,         2, K_STORE, 32'h0, 4'b1100, 32'hBEEF_BEEF);
        tbl[9]  = mk(i_sw,   32'h0000_4000, 32'hCAFE_F00D, 5'd12, 32'h0,         1, K_STORE, 32'h0, 4'b1111, 32'hCAFE_F00D);
        tbl[10] = mk(i_lw,   32'h0000_4004, 32'h0,         5'd31, 32'h89AB_CDEF, 2, K_LOAD,  32'h89AB_CDEF, 4'h0, 32'h0);
        tbl[11] = mk(i_beq,  32'h0000_0040, 32'h0,         5'd2,  32'h0,         1, K_NONE,  32'h0, 4'h0, 32'h0);
        tbl[12] = mk(i_jal,  32'h0000_0080, 32'h0,         5'd1,  32'h0,         1, K_NONE,  32'h0, 4'h0, 32'h0);
        tbl[13] = mk(i_lhu,  32'h0000_5001, 32'h0,         5'd3,  32'h0,         1, K_MIS,   32'h0, 4'h0, 32'h0);
        tbl[14] = mk(i_lb,   32'h0000_5003, 32'h0,         5'd4,  32'h7F00_0000, 1, K_LOAD,  32'h0000_007F, 4'h0, 32'h0);
        tbl[15] = mk(i_sh,   32'h0000_6001, 32'h0,         5'd4,  32'h0,         1, K_MIS,   32'h0, 4'h0, 32'h0);
        mem_ops[0] = i_lb; mem_ops[1] = i_lh; mem_ops[2] = i_lw; mem_ops[3] = i_lbu;
        mem_ops[4] = i_lhu; mem_ops[5] = i_sb; mem_ops[6] = i_sh; mem_ops[7] = i_sw;

        // Initial reset
        repeat (2) @(negedge clk);
        check_reset_outputs("init");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) do_op(tbl[i], $sformatf("tbl%0d", i));

        // Back-to-back pass-through at one per cycle
        req_valid = 1'b1; instr_in = i_add; addr = 32'h0000_0005; rd = 5'd3;
        @(negedge clk);
        check("b2b.ready", 32'(req_ready), 32'd1);
        instr_in = i_xori; addr = 32'hFFFF_FFFF; rd = 5'd4;
        check("b2b.wb0_valid", 32'(wb_valid), 32'd1);
        check("b2b.wb0_rd", 32'(wb_rd), 32'd3);
        check("b2b.wb0_data", wb_data, 32'h0000_0005);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b.wb1_valid", 32'(wb_valid), 32'd1);
        check("b2b.wb1_rd", 32'(wb_rd), 32'd4);
        check("b2b.wb1_data", wb_data, 32'hFFFF_FFFF);
        @(negedge clk);
        check("b2b.wb_drop", 32'(wb_valid), 32'd0);

        // Ack while idle is ignored
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        @(negedge clk);
        mem_ack = 1'b0;
        check("idle_ack.wb", 32'(wb_valid), 32'd0);
        check("idle_ack.req", 32'(mem_req), 32'd0);

        // Reset in BUS drops the request; a late ack produces nothing
        req_valid = 1'b1; instr_in = i_lw; addr = 32'h0000_7000; rd = 5'd9;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstbus.mem_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("rstbus");
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        mem_ack = 1'b0;
        check("late_ack.wb", 32'(wb_valid), 32'd0);
        check("late_ack.req", 32'(mem_req), 32'd0);
        @(negedge clk);
        check("late_ack.wb2", 32'(wb_valid), 32'd0);

        // Randomized ops against the model
        for (int n = 0; n < 300; n++) begin
            logic [5:0] op;
            vec_t v;
            if ($urandom_range(0, 1) == 1) op = mem_ops[$urandom_range(0, 7)];
            else                           op = 6'($urandom_range(0, 63));
            v = model(op, $urandom, $urandom, 5'($urandom), $urandom, int'($urandom_range(1, 4)));
            do_op(v, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
